sl_transmitter: RTL and testbench

//  Serial-line (SL) transmitter: serialises one 8..32-bit word, plus an optional parity bit, onto the two-wire SL bus.

---
 rtl/sl_transmitter.sv | 167 ++++++++++++++++
 tb/tb_sl_transmitter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sl_transmitter.sv
// Serial-line transmitter: shifts out an 8..32-bit word LSB first on the sl0/sl1 pair,
// with an optional odd-parity symbol and a closing stop symbol.
module sl_transmitter #(
    parameter int unsigned LOW_CYCLES  = 16,
    parameter int unsigned HIGH_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_valid,
    input  logic [31:0] tx_data,
    input  logic [5:0]  tx_len,
    input  logic        parity_en,
    output logic        tx_ready,
    output logic        busy,
    output logic        done,
    output logic        sl0,
    output logic        sl1
);

    localparam int unsigned MaxCycles = (LOW_CYCLES > HIGH_CYCLES) ? LOW_CYCLES : HIGH_CYCLES;
    localparam int unsigned PhW       = $clog2(MaxCycles);

    localparam logic [PhW-1:0] LowLast  = PhW'(LOW_CYCLES - 1);
    localparam logic [PhW-1:0] HighLast = PhW'(HIGH_CYCLES - 1);
    // The done cycle itself is the final high cycle of the stop symbol.
    localparam logic [PhW-1:0] StopLast = PhW'(HIGH_CYCLES - 2);

    typedef enum logic [2:0] {
        StGuard,
        StIdle,
        StLow,
        StHigh,
        StStopLow,
        StStopHigh
    } state_e;

    state_e         state_q;
    logic [PhW-1:0] phase_q;
    logic [5:0]     bit_cnt_q;
    logic [5:0]     len_q;
    logic [31:0]    shift_q;
    logic           par_pend_q;
    logic           par_q;

    logic           accept;
    logic [5:0]     len_clamped;

    assign accept = tx_valid & tx_ready;

    always_comb begin
        len_clamped = tx_len;
        if (tx_len < 6'd8) begin
            len_clamped = 6'd8;
        end else if (tx_len > 6'd32) begin
            len_clamped = 6'd32;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StGuard;
            phase_q    <= '0;
            bit_cnt_q  <= '0;
            len_q      <= '0;
            shift_q    <= '0;
            par_pend_q <= 1'b0;
            par_q      <= 1'b0;
            tx_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sl0        <= 1'b1;
            sl1        <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state_q)
                StGuard: begin
                    if (phase_q == HighLast) begin
                        state_q  <= StIdle;
                        phase_q  <= '0;
                        tx_ready <= 1'b1;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                StIdle: begin
                    if (accept) begin
                        shift_q    <= tx_data;
                        len_q      <= len_clamped;
                        par_pend_q <= parity_en;
                        // Running parity starts at 1 and already folds in bit 0.
                        par_q      <= ~tx_data[0];
                        bit_cnt_q  <= 6'd1;
                        sl0        <= tx_data[0];
                        sl1        <= ~tx_data[0];
                        tx_ready   <= 1'b0;
                        busy       <= 1'b1;
                        state_q    <= StLow;
                        phase_q    <= '0;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                StLow: begin
                    if (phase_q == LowLast) begin
                        sl0     <= 1'b1;
                        sl1     <= 1'b1;
                        state_q <= StHigh;
                        phase_q <= '0;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                StHigh: begin
                    if (phase_q == HighLast) begin
                        phase_q <= '0;
                        if (bit_cnt_q < len_q) begin
                            shift_q   <= shift_q >> 1;
                            sl0       <= shift_q[1];
                            sl1       <= ~shift_q[1];
                            par_q     <= par_q ^ shift_q[1];
                            bit_cnt_q <= bit_cnt_q + 6'd1;
                            state_q   <= StLow;
                        end else if (par_pend_q) begin
                            par_pend_q <= 1'b0;
                            sl0        <= par_q;
                            sl1        <= ~par_q;
                            state_q    <= StLow;
                        end else begin
                            sl0     <= 1'b0;
                            sl1     <= 1'b0;
                            state_q <= StStopLow;
                        end
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                StStopLow: begin
                    if (phase_q == LowLast) begin
                        sl0     <= 1'b1;
                        sl1     <= 1'b1;
                        state_q <= StStopHigh;
                        phase_q <= '0;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                StStopHigh: begin
                    if (phase_q == StopLast) begin
                        state_q  <= StIdle;
                        phase_q  <= '0;
                        done     <= 1'b1;
                        tx_ready <= 1'b1;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StGuard;
                    phase_q <= '0;
                    sl0     <= 1'b1;
                    sl1     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sl_transmitter.sv
// Scoreboard bench for sl_transmitter: a line monitor decodes symbols and checks each
// frame against hand-computed expectations when done pulses.
module tb_sl_transmitter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_valid = 1'b0;
    logic [31:0] tx_data = '0;
    logic [5:0]  tx_len = '0;
    logic        parity_en = 1'b0;
    logic        tx_ready;
    logic        busy;
    logic        done;
    logic        sl0;
    logic        sl1;

    sl_transmitter #(
        .LOW_CYCLES (16),
        .HIGH_CYCLES(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_len   (tx_len),
        .parity_en(parity_en),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done),
        .sl0      (sl0),
        .sl1      (sl1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          nsym;
        logic [63:0] bits;
        int          lat;
        int          gap;
    } exp_t;

    exp_t sb[$];
    int   acc_q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   done_cnt = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor / scoreboard checker
    logic        in_low = 1'b0;
    logic [1:0]  kind = '0;
    logic [1:0]  k;
    int          low_len = 0;
    int          high_len = 1000;
    int          nsym = 0;
    int          stops = 0;
    int          sym_err = 0;
    int          first_gap = 0;
    logic [63:0] bits = '0;
    exp_t        e;
    int          acc;

    always @(negedge clk) begin
        if (rst) begin
            in_low   = 1'b0;
            high_len = 1000;
            nsym     = 0;
            stops    = 0;
            sym_err  = 0;
            bits     = '0;
            acc_q.delete();
        end else begin
            if (!sl0 || !sl1) begin
                k = (!sl0 && !sl1) ? 2'd2 : (!sl1 ? 2'd1 : 2'd0);
                if (!in_low) begin
                    in_low  = 1'b1;
                    kind    = k;
                    low_len = 1;
                    if (nsym == 0 && stops == 0) first_gap = high_len;
                    else chk("intra_frame_gap", high_len, 16);
                end else begin
                    low_len++;
                    if (k != kind) sym_err++;
                end
            end else if (in_low) begin
                in_low = 1'b0;
                chk("low_width", low_len, 16);
                if (kind == 2'd2) stops++;
                else begin
                    if (stops != 0) sym_err++;
                    if (nsym < 64) bits[nsym] = kind[0];
                    nsym++;
                end
                high_len = 1;
            end else begin
                high_len++;
            end

            if (done) begin
                done_cnt++;
                if (sb.size() == 0 || acc_q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e   = sb.pop_front();
                    acc = acc_q.pop_front();
                    chk("data_symbols", nsym, e.nsym);
                    chk("symbol_bits", bits, e.bits);
                    chk("stop_symbols", stops, 1);
                    chk("symbol_shape", sym_err, 0);
                    chk("accept_to_done", cyc - acc, e.lat);
                    if (e.gap >= 0) chk("b2b_gap", first_gap, e.gap);
                end
                nsym    = 0;
                stops   = 0;
                sym_err = 0;
                bits    = '0;
            end

            if (tx_valid && tx_ready) acc_q.push_back(cyc);
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!tx_ready && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (!tx_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) chk("done_timeout", sb.size(), 0);
    endtask

    task automatic guard_check();
        int n = 0;
        int lines_bad = 0;
        while (!tx_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
            if (!(sl0 && sl1)) lines_bad++;
        end
        chk("guard_len", n, 16);
        chk("guard_lines_high", lines_bad, 0);
    endtask

    task automatic send(input logic [31:0] d, input logic [5:0] l, input logic p,
                        input int ens, input logic [63:0] eb, input int lat);
        exp_t x;
        wait_ready();
        tx_data   = d;
        tx_len    = l;
        parity_en = p;
        tx_valid  = 1'b1;
        x.nsym = ens;
        x.bits = eb;
        x.lat  = lat;
        x.gap  = -1;
        sb.push_back(x);
        @(posedge clk); #1;
        tx_valid  = 1'b0;
        // Mid-frame input changes must not disturb the frame.
        tx_data   = $urandom;
        tx_len    = 6'($urandom_range(0, 63));
        parity_en = ~p;
        chk("busy_after_accept", busy, 1);
        chk("ready_drops", tx_ready, 0);
        wait_drain();
    endtask

    initial begin
        int dc;
        exp_t x;
        #2ms;
        $display("FAIL global_timeout: got cyc=%0d want finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int dc;
        exp_t x;

        // Reset state and guard period
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_sl0", sl0, 1);
        chk("rst_sl1", sl1, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", tx_ready, 0);
        rst = 1'b0;
        guard_check();

        // 0xA5 N=8 parity: 1,0,1,0,0,1,0,1 then parity 1
        send(32'h0000_00A5, 6'd8, 1'b1, 9, 64'h1A5, 320);
        // All ones, 32 bits, no parity
        send(32'hFFFF_FFFF, 6'd32, 1'b0, 32, 64'hFFFF_FFFF, 1056);
        // Length clamps
        send(32'h0000_00C3, 6'd3, 1'b0, 8, 64'hC3, 288);
        send(32'h1234_5678, 6'd40, 1'b1, 33, 64'h0_1234_5678, 1088);
        // Bits above N ignored; 0x3C has four ones so parity is 1
        send(32'hFFFF_FF3C, 6'd8, 1'b1, 9, 64'h13C, 320);

        // Back-to-back with tx_valid held high
        wait_ready();
        tx_data   = 32'h0000_000F;
        tx_len    = 6'd8;
        parity_en = 1'b0;
        tx_valid  = 1'b1;
        x.nsym = 8; x.bits = 64'h0F; x.lat = 288; x.gap = -1;
        sb.push_back(x);
        @(posedge clk); #1;
        tx_data   = 32'h0000_0081;
        parity_en = 1'b1;
        x.nsym = 9; x.bits = 64'h181; x.lat = 320; x.gap = 16;
        sb.push_back(x);
        dc = 0;
        while (!done && dc < 400) begin
            @(posedge clk); #1;
            dc++;
        end
        chk("b2b_first_done_cycles", dc, 287);
        chk("b2b_ready_on_done", tx_ready, 1);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        chk("b2b_second_busy", busy, 1);
        chk("b2b_second_ready", tx_ready, 0);
        wait_drain();

        // Reset during the 4th symbol's low phase
        wait_ready();
        tx_data   = 32'h0000_00FF;
        tx_len    = 6'd8;
        parity_en = 1'b0;
        tx_valid  = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("mid_frame_sl1_low", sl1, 0);
        dc  = done_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_sl0", sl0, 1);
        chk("abort_sl1", sl1, 1);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        guard_check();
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, dc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
